// File: rtl/ddr3_cmd_responder.sv
// ddr3_cmd_responder: device-side DDR3 command decoder with per-bank timing, behavioural storage and CL read pipeline
module ddr3_cmd_responder #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4,
  parameter int T_RCD    = 5,
  parameter int T_RP     = 5,
  parameter int T_RFC    = 10,
  parameter int CL       = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [14:0] Addr_in,
  input  logic [2:0]  BA_in,
  input  logic        LDM,
  input  logic        UDM,
  input  logic [15:0] DQ_in,
  output logic [15:0] DQ_out,
  output logic        DQ_valid,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [7:0]  bank_open,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, OPENING, ACTIVE, CLOSING} st_t;
  localparam int CW = 16;
  localparam int AW = 3 + ROW_BITS + COL_BITS;

  st_t                 r_st   [8];
  st_t                 w_es   [8];
  st_t                 w_ns   [8];
  st_t                 w_bes;
  logic [CW-1:0]       r_cnt  [8];
  logic [CW-1:0]       w_ncnt [8];
  logic [CW-1:0]       r_rcnt;
  logic [ROW_BITS-1:0] r_row  [8];
  logic [15:0]         r_mem  [2**AW];
  logic [15:0]         r_pd   [CL];
  logic [CL-1:0]       r_pv;
  logic [2:0]          w_cmd, w_code;
  logic                w_act, w_rd, w_wr, w_pre, w_ref, w_nop, w_busy, w_ok;
  logic                w_any_nidle, w_any_opening;
  logic [7:0]          w_open;
  logic [AW-1:0]       w_addr;
  logic [15:0]         w_rdata;
  logic                w_unused;

  assign w_cmd    = {RAS, CAS, WE};
  assign w_act    = !CS && w_cmd == 3'b011;
  assign w_rd     = !CS && w_cmd == 3'b101;
  assign w_wr     = !CS && w_cmd == 3'b100;
  assign w_pre    = !CS && w_cmd == 3'b010;
  assign w_ref    = !CS && w_cmd == 3'b001;
  assign w_nop    = CS || w_cmd == 3'b111;
  assign w_busy   = busy && r_rcnt != '0;
  assign w_addr   = {BA_in, r_row[BA_in], Addr_in[COL_BITS-1:0]};
  assign w_rdata  = r_mem[w_addr];
  assign w_unused = ^Addr_in;

  // Effective state: a bank whose counter reads 0 already behaves as its destination state
  always_comb begin
    w_any_nidle   = 1'b0;
    w_any_opening = 1'b0;
    for (int b = 0; b < 8; b++) begin
      w_es[b] = (r_cnt[b] == '0 && r_st[b] == OPENING) ? ACTIVE :
                (r_cnt[b] == '0 && r_st[b] == CLOSING) ? IDLE : r_st[b];
      w_any_nidle   = w_any_nidle | (w_es[b] != IDLE);
      w_any_opening = w_any_opening | (w_es[b] == OPENING);
    end
    w_bes  = w_es[BA_in];
    w_code = (w_busy && !w_nop)                ? 3'd4 :
             (w_act && w_bes != IDLE)          ? 3'd1 :
             ((w_rd || w_wr) && w_bes != ACTIVE) ? 3'd2 :
             (w_ref && w_any_nidle)            ? 3'd3 :
             (w_pre && (Addr_in[10] ? w_any_opening : w_bes == OPENING)) ? 3'd5 : 3'd0;
    w_ok   = w_code == 3'd0;
    for (int b = 0; b < 8; b++) begin
      w_ns[b]   = w_es[b];
      w_ncnt[b] = (r_cnt[b] == '0) ? '0 : r_cnt[b] - 1'b1;
      if (w_ok && w_act && BA_in == 3'(b)) begin
        w_ns[b]   = OPENING;
        w_ncnt[b] = CW'(T_RCD - 1);
      end else if (w_ok && (((w_rd || w_wr) && Addr_in[10] && BA_in == 3'(b)) ||
                            (w_pre && (Addr_in[10] || BA_in == 3'(b)) && w_es[b] == ACTIVE))) begin
        w_ns[b]   = CLOSING;
        w_ncnt[b] = CW'(T_RP - 1);
      end
    end
  end

  always_comb begin
    for (int b = 0; b < 8; b++) w_open[b] = w_ns[b] == ACTIVE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int b = 0; b < 8; b++) begin
        r_st[b]  <= IDLE;
        r_cnt[b] <= '0;
      end
      r_rcnt    <= '0;
      r_pv      <= '0;
      busy      <= 1'b0;
      DQ_out    <= '0;
      DQ_valid  <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
      bank_open <= '0;
    end else begin
      for (int b = 0; b < 8; b++) begin
        r_st[b]  <= w_ns[b];
        r_cnt[b] <= w_ncnt[b];
      end
      r_rcnt    <= (w_ok && w_ref) ? CW'(T_RFC - 1) : (r_rcnt == '0) ? '0 : r_rcnt - 1'b1;
      busy      <= (w_ok && w_ref) ? 1'b1 : (r_rcnt == '0) ? 1'b0 : busy;
      r_pv[0]   <= w_ok && w_rd;
      for (int i = 1; i < CL; i++) r_pv[i] <= r_pv[i-1];
      DQ_valid  <= r_pv[CL-1];
      if (r_pv[CL-1]) DQ_out <= r_pd[CL-1];
      err       <= !w_ok;
      if (!w_ok) err_code <= w_code;
      bank_open <= w_open;
    end
  end

  // Storage, open rows and pipeline data survive reset; only the valid bits are flushed
  always_ff @(posedge CLK) begin
    r_pd[0] <= w_rdata;
    for (int i = 1; i < CL; i++) r_pd[i] <= r_pd[i-1];
    if (w_ok && w_act) r_row[BA_in] <= Addr_in[ROW_BITS-1:0];
    if (w_ok && w_wr && !LDM) r_mem[w_addr][7:0] <= DQ_in[7:0];
    if (w_ok && w_wr && !UDM) r_mem[w_addr][15:8] <= DQ_in[15:8];
  end
endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// tb_ddr3_cmd_responder: directed bench with read-data scoreboard for ddr3_cmd_responder
module tb_ddr3_cmd_responder;
  localparam int CL = 5;
  localparam logic [2:0] ACT = 3'b011, RD = 3'b101, WR = 3'b100, PRE = 3'b010, REF = 3'b001;

  logic        CLK = 0, RESET = 1, CS = 1, RAS = 1, CAS = 1, WE = 1, LDM = 0, UDM = 0;
  logic [14:0] Addr_in = '0;
  logic [2:0]  BA_in = '0;
  logic [15:0] DQ_in = '0;
  logic [15:0] DQ_out;
  logic        DQ_valid, err, busy;
  logic [2:0]  err_code;
  logic [7:0]  bank_open;

  typedef struct {int cyc; logic [15:0] d;} exp_t;
  exp_t q[$];
  int cyc = 0, total = 0, pass = 0, hi;

  ddr3_cmd_responder dut (
    .CLK(CLK), .RESET(RESET), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE),
    .Addr_in(Addr_in), .BA_in(BA_in), .LDM(LDM), .UDM(UDM), .DQ_in(DQ_in),
    .DQ_out(DQ_out), .DQ_valid(DQ_valid), .err(err), .err_code(err_code),
    .bank_open(bank_open), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic nop(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic cmd(input logic [2:0] c, input logic [2:0] ba, input logic [14:0] a,
                     input logic ldm = 0, input logic udm = 0, input logic [15:0] dq = 0);
    CS = 0; {RAS, CAS, WE} = c; BA_in = ba; Addr_in = a; LDM = ldm; UDM = udm; DQ_in = dq;
    @(negedge CLK);
    CS = 1; {RAS, CAS, WE} = 3'b111; LDM = 0; UDM = 0;
  endtask

  task automatic rd(input logic [2:0] ba, input logic [14:0] a, input logic [15:0] d);
    q.push_back('{cyc + 1 + CL, d});
    cmd(RD, ba, a);
  endtask

  // Read-data scoreboard: each expected word must appear exactly at its cycle, nothing else may
  always @(negedge CLK) if (!RESET) begin
    if (q.size() > 0 && cyc == q[0].cyc) begin
      chk("dq_valid", {31'b0, DQ_valid}, 1);
      chk("dq_data", {16'b0, DQ_out}, {16'b0, q[0].d});
      void'(q.pop_front());
    end else if (DQ_valid) chk("dq_spurious", {31'b0, DQ_valid}, 0);
  end

  initial begin
    nop(3);
    RESET = 0;
    nop(1);
    chk("rst_valid", {31'b0, DQ_valid}, 0);
    chk("rst_dq", {16'b0, DQ_out}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_code", {29'b0, err_code}, 0);
    chk("rst_open", {24'b0, bank_open}, 0);
    chk("rst_busy", {31'b0, busy}, 0);

    cmd(ACT, 0, 15'd1);
    nop(4);
    cmd(WR, 0, 15'd3, 0, 0, 16'hA5A5);
    chk("wr_trcd_err", {31'b0, err}, 0);
    chk("open_b0", {24'b0, bank_open}, 8'h01);
    rd(0, 15'd3, 16'hA5A5);
    cmd(WR, 0, 15'd4, 0, 0, 16'hFFFF);
    cmd(WR, 0, 15'd4, 1, 0, 16'h1234);
    rd(0, 15'd4, 16'h12FF);
    cmd(WR, 0, 15'd5, 0, 0, 16'hFFFF);
    cmd(WR, 0, 15'd5, 0, 1, 16'h1234);
    rd(0, 15'd5, 16'hFF34);
    rd(0, 15'd3, 16'hA5A5);
    nop(CL + 2);

    cmd(ACT, 2, 15'd7);
    cmd(RD, 2, 15'd0);
    chk("rd_early_err", {31'b0, err}, 1);
    chk("rd_early_code", {29'b0, err_code}, 2);
    nop(1);
    chk("err_pulse", {31'b0, err}, 0);
    chk("code_hold", {29'b0, err_code}, 2);
    nop(5);
    cmd(REF, 0, 15'd0);
    chk("ref_open_code", {29'b0, err_code}, 3);

    cmd(PRE, 0, 15'h400);
    nop(5);
    cmd(ACT, 0, 15'd1);
    cmd(ACT, 5, 15'd0);
    nop(6);
    chk("open_b0_b5", {24'b0, bank_open}, 8'h21);
    cmd(PRE, 0, 15'h400);
    chk("pre_all_open", {24'b0, bank_open}, 8'h00);
    chk("pre_all_err", {31'b0, err}, 0);
    nop(3);
    cmd(ACT, 0, 15'd1);
    chk("act_trp_m1_err", {31'b0, err}, 1);
    chk("act_trp_m1_code", {29'b0, err_code}, 1);
    cmd(ACT, 0, 15'd1);
    chk("act_trp_err", {31'b0, err}, 0);
    cmd(PRE, 0, 15'd0);
    chk("pre_opening_code", {29'b0, err_code}, 5);
    nop(5);

    cmd(PRE, 0, 15'h400);
    nop(5);
    cmd(REF, 0, 15'd0);
    chk("ref_ok_err", {31'b0, err}, 0);
    hi = int'(busy);
    repeat (3) begin nop(1); hi += int'(busy); end
    cmd(ACT, 0, 15'd1);
    chk("busy_err_code", {29'b0, err_code}, 4);
    chk("busy_err", {31'b0, err}, 1);
    hi += int'(busy);
    for (int i = 0; i < 20 && busy; i++) begin nop(1); hi += int'(busy); end
    chk("busy_len", hi, 10);
    cmd(ACT, 0, 15'd1);
    chk("act_after_ref", {31'b0, err}, 0);

    nop(4);
    cmd(RD, 0, 15'd3);
    nop(1);
    RESET = 1;
    nop(2);
    RESET = 0;
    nop(CL + 2);
    chk("rst2_valid", {31'b0, DQ_valid}, 0);
    chk("rst2_open", {24'b0, bank_open}, 0);
    cmd(ACT, 0, 15'd1);
    nop(4);
    rd(0, 15'd3, 16'hA5A5);
    rd(0, 15'd4, 16'h12FF);
    rd(0, 15'h405, 16'hFF34);
    chk("ap_open", {24'b0, bank_open}, 0);
    cmd(RD, 0, 15'd3);
    chk("rd_after_ap_code", {29'b0, err_code}, 2);
    nop(CL + 3);
    chk("sb_empty", q.size(), 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
